// File: rtl/snes_loader_pkg.sv
// Shared types and constants for the SNES ROM loader: FSM states, header length and header field offsets.
package snes_loader_pkg;

  typedef enum logic [2:0] {
    ST_HEADER = 3'd0,
    ST_DATA   = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  localparam int unsigned HDR_LEN_DEFAULT = 64;

  // Byte offsets of the captured header fields
  localparam int unsigned HDR_OFS_MAP = 0;
  localparam int unsigned HDR_OFS_ROM = 1;
  localparam int unsigned HDR_OFS_RAM = 2;

endpackage

// File: rtl/rom_word_fifo.sv
// Synchronous word FIFO holding {word address, 16-bit data}; exposes head and head+1 so the
// consumer can present the next entry on the cycle after a pop.
module rom_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 38
) (
  input  logic                     wclk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_c,
  output logic [WIDTH-1:0]         next_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CNT_W-1:0] count_d;

  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count_d = count + CNT_W'(do_push) - CNT_W'(do_pop);

  assign head_c = mem[rd_ptr];
  assign next_c = mem[rd_ptr + PTR_W'(1)];

  always_ff @(posedge wclk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
      empty <= (count_d == '0);
    end
  end

endmodule

// File: rtl/rom_writer.sv
// Streams a loader byte stream into ROM memory: strips the header, packs bytes into 16-bit words
// and issues held write requests. Optional ROM_WRITER_CHECKSUM_EN adds a payload checksum port.
module rom_writer
  import snes_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned HDR_LEN    = HDR_LEN_DEFAULT
) (
  input  logic              wclk,
  input  logic              resetn,
  input  logic [7:0]        din,
  input  logic              din_valid,
  input  logic              loading,
  input  logic              src_fail,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic [7:0]        map_ctrl,
  output logic [7:0]        rom_size,
  output logic [7:0]        ram_size,
  output logic [ADDR_W-1:0] rom_mask,
  output logic [23:0]       byte_cnt,
  output logic              done,
  output logic              fail
`ifdef ROM_WRITER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam int unsigned WADDR_W = ADDR_W - 1;
  localparam int unsigned WORD_W  = WADDR_W + 16;
  localparam int unsigned HC_W    = $clog2(HDR_LEN + 1);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

  state_t              state_q;
  state_t              state_d;
  logic [HC_W-1:0]     hdr_cnt;
  logic [7:0]          lo_byte;
  logic                loading_q;
  logic                loading_fall;
  logic                hdr_strobe;
  logic                pay_strobe;
  logic                push;
  logic [WORD_W-1:0]   push_data;
  logic                pop;
  logic                over_limit;
  logic [WADDR_W-1:0]  word_addr;
  logic [WORD_W-1:0]   fifo_head;
  logic [WORD_W-1:0]   fifo_next;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;

  function automatic logic [ADDR_W-1:0] calc_mask(input logic [7:0] size);
    int unsigned sh;
    sh = 32'(size) + 32'd10;
    if (sh >= ADDR_W) return '1;
    return (ADDR_W'(1) << sh) - ADDR_W'(1);
  endfunction

  assign loading_fall = loading_q && !loading;
  assign pop          = mem_we && mem_ack;
  assign over_limit   = (32'(byte_cnt) > 32'(rom_mask));
  assign word_addr    = WADDR_W'(byte_cnt >> 1);

  rom_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .wclk   (wclk),
    .resetn (resetn),
    .push   (push),
    .wdata  (push_data),
    .pop    (pop),
    .head_c (fifo_head),
    .next_c (fifo_next),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) state_q <= ST_HEADER;
    else         state_q <= state_d;
  end

  // Next state plus per-cycle header/payload/push strobes
  always_comb begin
    state_d    = state_q;
    hdr_strobe = 1'b0;
    pay_strobe = 1'b0;
    push       = 1'b0;
    push_data  = '0;
    case (state_q)
      ST_HEADER: begin
        if (loading_fall) begin
          state_d = ST_FAIL;
        end else if (din_valid) begin
          hdr_strobe = 1'b1;
          if (hdr_cnt == HC_W'(HDR_LEN - 1)) state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (din_valid) begin
          if (over_limit) begin
            state_d = ST_FAIL;
          end else begin
            pay_strobe = 1'b1;
            if (byte_cnt[0]) begin
              push      = 1'b1;
              push_data = {word_addr, din, lo_byte};
            end
          end
        end
        // A byte still waiting for its partner after this cycle needs a padded flush
        if (loading_fall && state_d == ST_DATA)
          state_d = (byte_cnt[0] ^ pay_strobe) ? ST_FLUSH : ST_DRAIN;
      end
      ST_FLUSH: begin
        if (!fifo_full || pop) begin
          push      = 1'b1;
          push_data = {word_addr, 8'h00, lo_byte};
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !mem_we) state_d = ST_DONE;
      end
      ST_DONE, ST_FAIL: ;
      default: state_d = ST_FAIL;
    endcase
    if (push && fifo_full && !pop) state_d = ST_FAIL;
    if (src_fail && state_q != ST_DONE) state_d = ST_FAIL;
  end

  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) begin
      loading_q <= 1'b0;
      hdr_cnt   <= '0;
      lo_byte   <= '0;
      map_ctrl  <= '0;
      rom_size  <= '0;
      ram_size  <= '0;
      rom_mask  <= '0;
      byte_cnt  <= '0;
      done      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      loading_q <= loading;
      if (hdr_strobe) begin
        hdr_cnt <= hdr_cnt + HC_W'(1);
        if (hdr_cnt == HC_W'(HDR_OFS_MAP)) map_ctrl <= din;
        if (hdr_cnt == HC_W'(HDR_OFS_ROM)) begin
          rom_size <= din;
          rom_mask <= calc_mask(din);
        end
        if (hdr_cnt == HC_W'(HDR_OFS_RAM)) ram_size <= din;
      end
      if (pay_strobe) begin
        byte_cnt <= byte_cnt + 24'd1;
        if (!byte_cnt[0]) lo_byte <= din;
      end
      if (state_d == ST_DONE) done <= 1'b1;
      if (state_d == ST_FAIL) fail <= 1'b1;
    end
  end

  // Write request: entries stay in the FIFO until acknowledged; the following entry is loaded on the ack
  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else if (mem_we) begin
      if (mem_ack) begin
        if (state_q != ST_FAIL && fifo_count >= CNT_W'(2)) begin
          mem_addr <= fifo_next[WORD_W-1:16];
          mem_din  <= fifo_next[15:0];
        end else begin
          mem_we <= 1'b0;
        end
      end
    end else if (!fifo_empty && state_q != ST_FAIL) begin
      mem_we   <= 1'b1;
      mem_addr <= fifo_head[WORD_W-1:16];
      mem_din  <= fifo_head[15:0];
    end
  end

`ifdef ROM_WRITER_CHECKSUM_EN
  // Wrapping sum of accepted payload bytes; the flush pad is never summed
  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn)         checksum <= '0;
    else if (pay_strobe) checksum <= checksum + 16'(din);
  end
`endif

endmodule

// File: tb/tb_rom_writer.sv
// Directed self-checking bench for rom_writer; define ROM_WRITER_CHECKSUM_EN to also exercise the checksum port.
module tb_rom_writer;

  localparam int unsigned ADDR_W = 23;

  logic              wclk = 1'b0;
  logic              resetn = 1'b0;
  logic [7:0]        din = 8'h00;
  logic              din_valid = 1'b0;
  logic              loading = 1'b0;
  logic              src_fail = 1'b0;
  logic [ADDR_W-2:0] mem_addr;
  logic [15:0]       mem_din;
  logic              mem_we;
  logic              mem_ack = 1'b0;
  logic [7:0]        map_ctrl;
  logic [7:0]        rom_size;
  logic [7:0]        ram_size;
  logic [ADDR_W-1:0] rom_mask;
  logic [23:0]       byte_cnt;
  logic              done;
  logic              fail;
`ifdef ROM_WRITER_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic ack_en = 1'b0;
  logic [ADDR_W-2:0] wr_addr_q[$];
  logic [15:0]       wr_data_q[$];
  int we_cycles = 0;
  int base;
  int we0;

  rom_writer dut (
    .wclk      (wclk),
    .resetn    (resetn),
    .din       (din),
    .din_valid (din_valid),
    .loading   (loading),
    .src_fail  (src_fail),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .mem_ack   (mem_ack),
    .map_ctrl  (map_ctrl),
    .rom_size  (rom_size),
    .ram_size  (ram_size),
    .rom_mask  (rom_mask),
    .byte_cnt  (byte_cnt),
    .done      (done),
`ifdef ROM_WRITER_CHECKSUM_EN
    .fail      (fail),
    .checksum  (checksum)
`else
    .fail      (fail)
`endif
  );

  always #5 wclk = ~wclk;

  // Memory controller model: one-cycle ack, one cycle after mem_we is seen
  always @(posedge wclk) begin
    #1;
    mem_ack = ack_en && mem_we && !mem_ack;
  end

  always @(negedge wclk) begin
    if (mem_we) we_cycles++;
    if (mem_we && mem_ack) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_din);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [31:0] ea, input logic [31:0] ed);
    check({tag, "_addr"}, (base + idx < wr_addr_q.size()) ? 32'(wr_addr_q[base + idx]) : 32'hDEAD_BEEF, ea);
    check({tag, "_data"}, (base + idx < wr_data_q.size()) ? 32'(wr_data_q[base + idx]) : 32'hDEAD_BEEF, ed);
  endtask

  task automatic do_reset();
    @(negedge wclk);
    resetn = 1'b0; din_valid = 1'b0; loading = 1'b0; src_fail = 1'b0; ack_en = 1'b0;
    repeat (2) @(negedge wclk);
    resetn = 1'b1;
  endtask

  task automatic strobe(input logic [7:0] b);
    @(negedge wclk);
    din = b; din_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge wclk);
      din_valid = 1'b0;
    end
  endtask

  task automatic send_header(input logic [7:0] rs);
    logic [7:0] b;
    loading = 1'b1;
    for (int i = 0; i < 64; i++) begin
      b = (i == 0) ? 8'h21 : (i == 1) ? rs : (i == 2) ? 8'h03 : 8'(i + 64);
      strobe(b);
    end
  endtask

  task automatic end_stream();
    @(negedge wclk);
    din_valid = 1'b0; loading = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge wclk);
      if (done || fail) break;
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    @(negedge wclk);
    check("rst_mem_we",   32'(mem_we),   32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_din",  32'(mem_din),  32'd0);
    check("rst_map_ctrl", 32'(map_ctrl), 32'd0);
    check("rst_rom_size", 32'(rom_size), 32'd0);
    check("rst_ram_size", 32'(ram_size), 32'd0);
    check("rst_rom_mask", 32'(rom_mask), 32'd0);
    check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_fail",     32'(fail),     32'd0);

    // Basic 4-byte payload
    do_reset();
    base = wr_addr_q.size();
    ack_en = 1'b1;
    send_header(8'h07);
    strobe(8'h11); strobe(8'h22); strobe(8'h33); strobe(8'h44);
    end_stream();
    wait_done(200);
    check("b_done",     32'(done), 32'd1);
    check("b_fail",     32'(fail), 32'd0);
    check("b_nwr",      32'(wr_addr_q.size() - base), 32'd2);
    check_wr("b_wr0", 0, 32'd0, 32'h2211);
    check_wr("b_wr1", 1, 32'd1, 32'h4433);
    check("b_rom_mask", 32'(rom_mask), 32'h1FFFF);
    check("b_map_ctrl", 32'(map_ctrl), 32'h21);
    check("b_rom_size", 32'(rom_size), 32'h07);
    check("b_ram_size", 32'(ram_size), 32'h03);
    check("b_byte_cnt", 32'(byte_cnt), 32'd4);
    strobe(8'h99);
    idle(4);
    check("b_done_ignore_cnt", 32'(byte_cnt), 32'd4);
    check("b_done_ignore_wr",  32'(wr_addr_q.size() - base), 32'd2);

    // Odd-length payload flushes a padded word
    do_reset();
    base = wr_addr_q.size();
    ack_en = 1'b1;
    send_header(8'h07);
    strobe(8'hAA); strobe(8'hBB); strobe(8'hCC);
    end_stream();
    wait_done(200);
    check("o_done",     32'(done), 32'd1);
    check("o_nwr",      32'(wr_addr_q.size() - base), 32'd2);
    check_wr("o_wr0", 0, 32'd0, 32'hBBAA);
    check_wr("o_wr1", 1, 32'd1, 32'h00CC);
    check("o_byte_cnt", 32'(byte_cnt), 32'd3);

    // Truncated header
    do_reset();
    we0 = we_cycles;
    loading = 1'b1;
    for (int i = 0; i < 10; i++) strobe(8'(i));
    end_stream();
    idle(5);
    check("t_fail", 32'(fail), 32'd1);
    check("t_done", 32'(done), 32'd0);
    check("t_we_cycles", 32'(we_cycles - we0), 32'd0);

    // Ack withheld: FIFO overflows, only the outstanding request completes
    do_reset();
    base = wr_addr_q.size();
    send_header(8'h07);
    for (int i = 0; i < 12; i++) strobe(8'(8'h10 + i));
    idle(40);
    check("w_fail",    32'(fail), 32'd1);
    check("w_nwr0",    32'(wr_addr_q.size() - base), 32'd0);
    check("w_we_held", 32'(mem_we), 32'd1);
    ack_en = 1'b1;
    idle(10);
    check("w_nwr1",    32'(wr_addr_q.size() - base), 32'd1);
    check_wr("w_wr0", 0, 32'd0, 32'h1110);
    check("w_we_drop", 32'(mem_we), 32'd0);

    // Source error in DATA
    do_reset();
    ack_en = 1'b1;
    send_header(8'h07);
    strobe(8'h01); strobe(8'h02);
    @(negedge wclk);
    din_valid = 1'b0; src_fail = 1'b1;
    @(negedge wclk);
    src_fail = 1'b0;
    check("s_fail", 32'(fail), 32'd1);
    check("s_done", 32'(done), 32'd0);

    // Reset during an outstanding request, then a clean reload
    do_reset();
    send_header(8'h07);
    strobe(8'h5A); strobe(8'hA5);
    idle(3);
    check("r_we_pre", 32'(mem_we), 32'd1);
    resetn = 1'b0; loading = 1'b0;
    #1;
    check("r_we_drop",  32'(mem_we),   32'd0);
    check("r_addr_rst", 32'(mem_addr), 32'd0);
    check("r_din_rst",  32'(mem_din),  32'd0);
    @(negedge wclk);
    resetn = 1'b1;
    base = wr_addr_q.size();
    ack_en = 1'b1;
    send_header(8'h07);
    strobe(8'h55); strobe(8'h66); strobe(8'h77); strobe(8'h88);
    end_stream();
    wait_done(200);
    check("r_done", 32'(done), 32'd1);
    check("r_nwr",  32'(wr_addr_q.size() - base), 32'd2);
    check_wr("r_wr0", 0, 32'd0, 32'h6655);
    check_wr("r_wr1", 1, 32'd1, 32'h8877);

    // ROM size boundary: rom_size 0 allows exactly 1024 payload bytes
    do_reset();
    base = wr_addr_q.size();
    ack_en = 1'b1;
    send_header(8'h00);
    for (int i = 0; i < 1024; i++) begin
      strobe(8'(i));
      idle(1);
    end
    idle(8);
    check("l_rom_mask", 32'(rom_mask), 32'h3FF);
    check("l_byte_cnt", 32'(byte_cnt), 32'd1024);
    check("l_fail0",    32'(fail), 32'd0);
    check("l_nwr",      32'(wr_addr_q.size() - base), 32'd512);
    check_wr("l_wr_last", 511, 32'd511, 32'hFFFE);
    strobe(8'h00);
    idle(2);
    check("l_fail1", 32'(fail), 32'd1);

`ifdef ROM_WRITER_CHECKSUM_EN
    do_reset();
    base = wr_addr_q.size();
    ack_en = 1'b1;
    send_header(8'h07);
    strobe(8'h01); strobe(8'h02); strobe(8'hFF);
    end_stream();
    wait_done(200);
    check("c_done",     32'(done), 32'd1);
    check("c_checksum", 32'(checksum), 32'h0102);
    check_wr("c_wr0", 0, 32'd0, 32'h0201);
    check_wr("c_wr1", 1, 32'd1, 32'h00FF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
